// File: rtl/line_fetch_scheduler.sv
// line_fetch_scheduler
//   Arbitrates a single-port framebuffer RAM between display line fetches and
//   host writes. A rising vertical sync schedules line 0, and each falling data
//   enable schedules the next active line. A line fetch is a burst of
//   WORDS_PER_LINE consecutive reads that are copied into a double-buffered
//   line buffer. Host writes fill the idle cycles. A fetch always takes
//   priority over a host write, and a fetch that is already running is never
//   preempted.
//
// Ports
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_de, i_vs           : data enable / vertical sync from the timing generator
//   i_wr_req             : host write request, held until o_wr_ack
//   i_wr_addr, i_wr_data : host write word address / data
//   o_wr_ack             : one-cycle pulse in the cycle the host write hits RAM
//   o_ram_addr, o_ram_we : RAM address / write enable
//   o_ram_wdata          : RAM write data
//   i_ram_rdata          : RAM read data, valid one cycle after the address
//   o_lb_we, o_lb_addr   : line-buffer write strobe / word index
//   o_lb_data            : line-buffer write data (RAM read data passed through)
//   o_lb_bank            : bank being filled; the display reads ~o_lb_bank
//   o_underrun           : sticky, set when a line trigger is dropped
module line_fetch_scheduler #(
  parameter int WORDS_PER_LINE = 40,
  parameter int ACTIVE_LINES   = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_de,
  input  logic        i_vs,
  input  logic        i_wr_req,
  input  logic [14:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  output logic [14:0] o_ram_addr,
  output logic        o_ram_we,
  output logic [15:0] o_ram_wdata,
  input  logic [15:0] i_ram_rdata,
  output logic        o_lb_we,
  output logic [5:0]  o_lb_addr,
  output logic [15:0] o_lb_data,
  output logic        o_lb_bank,
  output logic        o_underrun
);

  localparam int          LINE_W    = (ACTIVE_LINES > 2) ? $clog2(ACTIVE_LINES) : 1;
  localparam logic [14:0] LINE_STEP = 15'(WORDS_PER_LINE);
  localparam logic [5:0]  LAST_WORD = 6'(WORDS_PER_LINE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOST  = 2'd2;

  logic [1:0]        state_r;
  logic              pending_r;
  logic [LINE_W-1:0] line_r;
  logic [14:0]       base_r;
  logic              de_r;
  logic              vs_r;
  logic [5:0]        word_r;
  logic [14:0]       ram_addr_r;
  logic [15:0]       ram_wdata_r;
  logic              ram_we_r;
  logic              wr_ack_r;
  logic              lb_we_r;
  logic [5:0]        lb_addr_r;
  logic              lb_bank_r;
  logic              underrun_r;

  logic              vs_trig_s;
  logic              de_trig_s;
  logic              line_room_s;
  logic              busy_s;
  logic              trig_s;
  logic              sched_s;
  logic              overrun_s;
  logic [14:0]       base_sched_s;
  logic [LINE_W-1:0] line_sched_s;
  logic [14:0]       fetch_base_s;

  // Trigger edge detection and the decision to schedule or drop a line fetch.
  always_comb begin
    vs_trig_s   = i_vs & ~vs_r;
    de_trig_s   = ~i_de & de_r;
    line_room_s = (32'(line_r) + 32'd1) < 32'(ACTIVE_LINES);
    busy_s      = (state_r == ST_FETCH) | pending_r;
    // An out-of-range de trigger is ignored outright, so it never counts as an overrun.
    trig_s      = vs_trig_s | (de_trig_s & line_room_s);
    sched_s     = trig_s & ~busy_s;
    overrun_s   = trig_s & busy_s;
    if (vs_trig_s) begin
      base_sched_s = 15'd0;
      line_sched_s = {LINE_W{1'b0}};
    end else begin
      // Base advances by a fixed stride, wrapping modulo 2^15; no multiply.
      base_sched_s = base_r + LINE_STEP;
      line_sched_s = line_r + LINE_W'(1'b1);
    end
    // The burst may start in the same cycle its trigger arrives.
    if (sched_s) begin
      fetch_base_s = base_sched_s;
    end else begin
      fetch_base_s = base_r;
    end
  end

  // Registered timing inputs, line counter, fetch base and sticky overrun flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_r       <= 1'b0;
      de_r       <= 1'b0;
      base_r     <= 15'd0;
      line_r     <= {LINE_W{1'b0}};
      underrun_r <= 1'b0;
    end else begin
      vs_r <= i_vs;
      de_r <= i_de;
      if (sched_s) begin
        base_r <= base_sched_s;
        line_r <= line_sched_s;
      end
      if (overrun_s) begin
        underrun_r <= 1'b1;
      end
    end
  end

  // Port arbiter FSM driving the registered RAM port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      pending_r   <= 1'b0;
      word_r      <= 6'd0;
      ram_addr_r  <= 15'd0;
      ram_wdata_r <= 16'd0;
      ram_we_r    <= 1'b0;
      wr_ack_r    <= 1'b0;
    end else begin
      ram_we_r <= 1'b0;
      wr_ack_r <= 1'b0;
      // A trigger taken during HOST stays pending until the FSM is back in IDLE.
      if (sched_s) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (pending_r | sched_s) begin
            state_r    <= ST_FETCH;
            pending_r  <= 1'b1;
            word_r     <= 6'd0;
            ram_addr_r <= fetch_base_s;
          end else if (i_wr_req) begin
            state_r     <= ST_HOST;
            ram_addr_r  <= i_wr_addr;
            ram_wdata_r <= i_wr_data;
            ram_we_r    <= 1'b1;
            wr_ack_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (word_r == LAST_WORD) begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
          end else begin
            word_r     <= word_r + 6'd1;
            ram_addr_r <= ram_addr_r + 15'd1;
          end
        end
        // A single write cycle; the mandatory IDLE afterwards limits the host to one write every two cycles.
        ST_HOST: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Line-buffer write port, one cycle behind the RAM read; bank flips after the final word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lb_we_r   <= 1'b0;
      lb_addr_r <= 6'd0;
      lb_bank_r <= 1'b0;
    end else begin
      lb_we_r <= (state_r == ST_FETCH);
      if (state_r == ST_FETCH) begin
        lb_addr_r <= word_r;
      end
      if (lb_we_r && (lb_addr_r == LAST_WORD)) begin
        lb_bank_r <= ~lb_bank_r;
      end
    end
  end

  assign o_wr_ack    = wr_ack_r;
  assign o_ram_addr  = ram_addr_r;
  assign o_ram_we    = ram_we_r;
  assign o_ram_wdata = ram_wdata_r;
  assign o_lb_we     = lb_we_r;
  assign o_lb_addr   = lb_addr_r;
  // Read data is passed straight through; it is held at zero between strobes.
  assign o_lb_data   = lb_we_r ? i_ram_rdata : 16'd0;
  assign o_lb_bank   = lb_bank_r;
  assign o_underrun  = underrun_r;

endmodule
